imm_encode: RTL and testbench
=============================

Name: imm_encode

Overview:
- Streaming immediate encoder: the inverse of the datapath immediate extender.
- Takes a 32-bit signed immediate, an immsrc selector (I/S/B/J) and a base instruction word. Inserts the immediate bits at their RISC-V field positions, range-checks the immediate and flags misalignment.
- Used by the self-test instruction generator and the program loader.
- Two-stage valid/ready pipeline with error counters.

Parameters:
- ERR_DROP, 0, 1 = errored items are consumed and not output; 0 = errored items are output with err set.
- CNT_W, 16, width of the saturating item and error counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input item valid.
- in_ready  out  1  encoder can accept an item.
- immsrc  in  2  00=I, 01=S, 10=B, 11=J (same coding as the extender).
- imm  in  32  signed immediate, byte offset for B/J.
- base  in  32  instruction word; immediate field bits are ignored and overwritten.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- instr  out  32  encoded instruction.
- err  out  2  bit0 = out of range, bit1 = misaligned (B/J with imm[0]=1).
- err_sticky  out  1  set on any errored item; cleared only by reset.
- enc_count  out  CNT_W  items output, saturating.
- err_count  out  CNT_W  errored items, saturating; counts dropped items too.

Behaviour:
- Reset applies when reset=0 at a clock edge:
  - s1_valid, s2_valid, out_valid = 0.
  - instr, err = 0.
  - err_sticky = 0; both counters = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight items with no output.
- Handshake:
  - Transfer occurs when valid && ready at a clock edge.
  - out_valid, instr and err stay stable until accepted.
  - in_ready does not depend combinationally on in_valid.
- Pipeline:
  - Stage1 registers immsrc, imm, base and computes the range/align flags.
  - Stage2 registers instr, err and drives out_valid.
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - Latency from input accept to out_valid is 2 cycles.
  - Full throughput is 1 item/cycle when out_ready=1.
  - Capacity is 2 items; order is preserved.
- Range checks (err bit0):
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
- Alignment check (err bit1): B and J require imm[0]=0. I and S are never misaligned.
- Encoding (bits not listed come from base):
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5]; instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: instr[31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - Out-of-range immediates are truncated to these bits.
- Round-trip property: for err=0, extend(instr[31:7], immsrc) == imm.
- Errors:
  - err_sticky and err_count update when the errored item leaves stage1.
  - If ERR_DROP=1, the errored item does not enter stage2 and enc_count does not increment.
- enc_count increments on each out_valid && out_ready.
- Both counters hold at all-ones (saturate).
- A simultaneous input accept and output accept in a full pipeline is allowed and loses no item.

Test Plan:
- I-type round trip: immsrc=00, imm=0xFFFFFFFF, base=0x00000013.
  - Required: instr=0xFFF00013, err=00, out_valid two cycles after accept.
- B-type boundary: immsrc=10, imm=0x00000800, base=0x00000063.
  - Required: instr=0x000000E3, err=00.
  - imm=0xFFFFF000 → instr=0x80000063, err=00.
- J-type misaligned: immsrc=11, imm=3, base=0x0000006F, ERR_DROP=0.
  - Required: instr=0x0020006F, err=10, err_sticky=1, err_count=1.
- S-type out of range: immsrc=01, imm=0x00000800, base=0x00002023.
  - ERR_DROP=0: instr=0x80002023, err=01.
  - ERR_DROP=1: no output, enc_count unchanged, err_count=1.
- Backpressure: out_ready=0 for 6 cycles, input presents 3 valid items back to back.
  - Required: 2 items accepted, then in_ready=0 while out_ready=0.
  - After out_ready=1: all 3 items output in order, enc_count=3.
- Reset mid-stream: 2 items in flight, assert reset for one edge.
  - Required: out_valid=0 and counters=0 next cycle; no stale word appears afterwards.

Source files
------------

// File: rtl/imm_encode.sv
// Streaming RISC-V immediate encoder: the inverse of the datapath immediate
// extender. Places a signed immediate into the I/S/B/J field positions of a
// base instruction word, range-checks it and flags B/J misalignment.
// Two-stage valid/ready pipeline with saturating item and error counters.
module imm_encode #(
  parameter bit ERR_DROP = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [1:0]       err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Same coding as the immediate extender.
  typedef enum logic [1:0] {
    SRC_I = 2'b00,
    SRC_S = 2'b01,
    SRC_B = 2'b10,
    SRC_J = 2'b11
  } immsrc_e;

  // Stage 1: captured request.
  logic        s1_valid_q;
  immsrc_e     s1_src_q;
  logic [31:0] s1_imm_q;
  logic [31:0] s1_base_q;

  // Stage 2: encoded result.
  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic [1:0]  s2_err_q;

  logic             err_sticky_q;
  logic [CNT_W-1:0] enc_count_q;
  logic [CNT_W-1:0] err_count_q;

  // Stage-1 combinational results.
  logic        range_ok;
  logic        aligned;
  logic [1:0]  s1_flags;
  logic [31:0] s1_enc;

  // Handshake / movement.
  logic s2_free;
  logic s1_err;
  logic s1_drop;
  logic s1_leave;
  logic s2_load;
  logic in_accept;
  logic out_accept;

  // Range/alignment check and field insertion for the item held in stage 1.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned; that is what keeps combinational logic from becoming a latch.
  always_comb begin
    range_ok = 1'b1;
    aligned  = 1'b1;
    s1_enc   = s1_base_q;
    unique case (s1_src_q)
      SRC_I: begin
        range_ok      = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
        s1_enc[31:20] = s1_imm_q[11:0];
      end
      SRC_S: begin
        range_ok      = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
        s1_enc[31:25] = s1_imm_q[11:5];
        s1_enc[11:7]  = s1_imm_q[4:0];
      end
      SRC_B: begin
        range_ok      = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
        aligned       = ~s1_imm_q[0];
        s1_enc[31]    = s1_imm_q[12];
        s1_enc[30:25] = s1_imm_q[10:5];
        s1_enc[11:8]  = s1_imm_q[4:1];
        s1_enc[7]     = s1_imm_q[11];
      end
      SRC_J: begin
        range_ok      = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);
        aligned       = ~s1_imm_q[0];
        s1_enc[31]    = s1_imm_q[20];
        s1_enc[30:21] = s1_imm_q[10:1];
        s1_enc[20]    = s1_imm_q[11];
        s1_enc[19:12] = s1_imm_q[19:12];
      end
    endcase
    s1_flags = {~aligned, ~range_ok};
  end

  // A stage frees when empty or when its contents move on this cycle; a
  // dropped item leaves stage 1 without needing room in stage 2.
  assign s2_free    = !s2_valid_q || out_ready;
  assign s1_err     = |s1_flags;
  assign s1_drop    = ERR_DROP && s1_err;
  assign s1_leave   = s1_valid_q && (s1_drop || s2_free);
  assign s2_load    = s1_valid_q && !s1_drop && s2_free;
  assign in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_accept  = in_valid && in_ready;
  assign out_accept = s2_valid_q && out_ready;

  // Stage 1 register: capture a new request or empty out when it moves on.
  // NOTE: only the valid bit is reset; the payload is qualified by it, so
  // resetting the data registers would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
    end else if (in_accept) begin
      s1_valid_q <= 1'b1;
      s1_src_q   <= immsrc_e'(immsrc);
      s1_imm_q   <= imm;
      s1_base_q  <= base;
    end else if (s1_leave) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 register: hold the encoded word stable until downstream takes it.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      s2_instr_q <= s1_enc;
      s2_err_q   <= s1_flags;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Sticky error flag and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_sticky_q <= 1'b0;
      enc_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      if (s1_leave && s1_err) begin
        err_sticky_q <= 1'b1;
        if (!(&err_count_q)) err_count_q <= err_count_q + 1'b1;
      end
      if (out_accept && !(&enc_count_q)) enc_count_q <= enc_count_q + 1'b1;
    end
  end

  assign out_valid  = s2_valid_q;
  assign instr      = s2_instr_q;
  assign err        = s2_err_q;
  assign err_sticky = err_sticky_q;
  assign enc_count  = enc_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode. dut0 keeps errored items (ERR_DROP=0,
// 16-bit counters); dut1 drops them (ERR_DROP=1, 4-bit counters so that
// saturation is reachable quickly).
module tb_imm_encode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1;
  logic [1:0]  immsrc0 = '0, err0;
  logic [31:0] imm0 = '0, base0 = '0, instr0;
  logic        sticky0;
  logic [15:0] enc0, errc0;

  // dut1 signals
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [1:0]  immsrc1 = '0, err1;
  logic [31:0] imm1 = '0, base1 = '0, instr1;
  logic        sticky1;
  logic [3:0]  enc1, errc1;

  imm_encode #(.ERR_DROP(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .immsrc(immsrc0), .imm(imm0), .base(base0), .out_valid(out_valid0),
    .out_ready(out_ready0), .instr(instr0), .err(err0), .err_sticky(sticky0),
    .enc_count(enc0), .err_count(errc0)
  );

  imm_encode #(.ERR_DROP(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .immsrc(immsrc1), .imm(imm1), .base(base1), .out_valid(out_valid1),
    .out_ready(out_ready1), .instr(instr1), .err(err1), .err_sticky(sticky1),
    .enc_count(enc1), .err_count(errc1)
  );

  int vec = 0;
  int miscmp = 0;
  int exp_enc0 = 0;
  int exp_errc0 = 0;

  int bnd [12] = '{2047, -2048, 2048, -2049, 4095, -4096, 4096, -4097,
                   1048575, -1048576, 1048576, -1048577};

  // ---------------- reference model (from the field rules) ----------------
  function automatic logic [1:0] model_err(input logic [1:0] s, input logic [31:0] i);
    int v, lo, hi;
    logic bad, mis;
    v = $signed(i);
    case (s)
      2'd2:    begin lo = -4096;    hi = 4095;    end
      2'd3:    begin lo = -1048576; hi = 1048575; end
      default: begin lo = -2048;    hi = 2047;    end
    endcase
    bad = (v < lo) || (v > hi);
    mis = (s >= 2'd2) && i[0];
    return {mis, bad};
  endfunction

  function automatic logic [31:0] model_enc(input logic [1:0] s, input logic [31:0] i,
                                            input logic [31:0] b);
    case (s)
      2'd0: return (b & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
      2'd1: return (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
      2'd2: return (b & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31) |
                   (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8) |
                   (((i >> 11) & 32'h1) << 7);
      default: return (b & 32'h0000_0FFF) | (((i >> 20) & 32'h1) << 31) |
                   (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20) |
                   (((i >> 12) & 32'hFF) << 12);
    endcase
  endfunction

  // The datapath extender, used for the round-trip property.
  function automatic logic [31:0] extend(input logic [1:0] s, input logic [31:0] w);
    case (s)
      2'd0: return {{20{w[31]}}, w[31:20]};
      2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    int r;
    case ($urandom_range(0, 4))
      0: r = int'($urandom);
      1: r = int'($urandom_range(0, 4095)) - 2048;
      2: r = int'($urandom_range(0, 8191)) - 4096;
      3: r = int'($urandom_range(0, 2097151)) - 1048576;
      default: r = bnd[$urandom_range(0, 11)] & ~int'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_enc0 = 0; exp_errc0 = 0;
  endtask

  // One item through idle dut0 with out_ready=1; reports latency in cycles.
  task automatic xfer0(input logic [1:0] s, input logic [31:0] i, input logic [31:0] b,
                       output logic [31:0] ins, output logic [1:0] e, output int lat);
    ins = 'x; e = 'x; lat = -1;
    @(posedge clk); #1;
    out_ready0 = 1'b1; immsrc0 = s; imm0 = i; base0 = b; in_valid0 = 1'b1;
    @(negedge clk);
    if (in_ready0) begin
      @(posedge clk); #1; in_valid0 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (out_valid0) begin ins = instr0; e = err0; lat = k; break; end
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1; in_valid0 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vec++; if (out_valid0 !== 1'b0) begin miscmp++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
    vec++; if (instr0 !== 32'h0) begin miscmp++; $display("FAIL reset_instr: got %h want 0", instr0); end
    vec++; if (err0 !== 2'b00) begin miscmp++; $display("FAIL reset_err: got %b want 00", err0); end
    vec++; if (sticky0 !== 1'b0) begin miscmp++; $display("FAIL reset_sticky: got %b want 0", sticky0); end
    vec++; if (enc0 !== 16'd0 || errc0 !== 16'd0) begin miscmp++; $display("FAIL reset_counters: got %0d/%0d want 0/0", enc0, errc0); end
    vec++; if (in_ready0 !== 1'b1) begin miscmp++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
  endtask

  task automatic test_directed(input string nm, input logic [1:0] s, input logic [31:0] i,
                               input logic [31:0] b, input logic [31:0] want_i,
                               input logic [1:0] want_e);
    logic [31:0] ins; logic [1:0] e; int lat;
    xfer0(s, i, b, ins, e, lat);
    exp_enc0++;
    if (want_e != 2'b00) exp_errc0++;
    vec++; if (lat !== 2) begin miscmp++; $display("FAIL %s_latency: got %0d want 2", nm, lat); end
    vec++; if (ins !== want_i) begin miscmp++; $display("FAIL %s_instr: got %h want %h", nm, ins, want_i); end
    vec++; if (e !== want_e) begin miscmp++; $display("FAIL %s_err: got %b want %b", nm, e, want_e); end
    vec++; if (enc0 !== 16'(exp_enc0)) begin miscmp++; $display("FAIL %s_enc_count: got %0d want %0d", nm, enc0, exp_enc0); end
    vec++; if (errc0 !== 16'(exp_errc0)) begin miscmp++; $display("FAIL %s_err_count: got %0d want %0d", nm, errc0, exp_errc0); end
    vec++; if (sticky0 !== (exp_errc0 > 0)) begin miscmp++; $display("FAIL %s_sticky: got %b want %b", nm, sticky0, exp_errc0 > 0); end
  endtask

  task automatic test_drop();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    out_ready1 = 1'b1; immsrc1 = 2'b01; imm1 = 32'h0000_0800; base1 = 32'h0000_2023;
    in_valid1 = 1'b1;
    @(posedge clk); #1; in_valid1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid1) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miscmp++; $display("FAIL drop_no_output: got %b want 0", seen); end
    vec++; if (enc1 !== 4'd0) begin miscmp++; $display("FAIL drop_enc_count: got %0d want 0", enc1); end
    vec++; if (errc1 !== 4'd1) begin miscmp++; $display("FAIL drop_err_count: got %0d want 1", errc1); end
    vec++; if (sticky1 !== 1'b1) begin miscmp++; $display("FAIL drop_sticky: got %b want 1", sticky1); end
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3];
    int idx, ocnt;
    for (int k = 0; k < 3; k++) want[k] = model_enc(2'b00, 32'(k * 7 + 1), 32'h0000_0013);
    idx = 0; ocnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      out_ready0 = (c >= 6);
      in_valid0 = (idx < 3);
      immsrc0 = 2'b00; imm0 = 32'(idx * 7 + 1); base0 = 32'h0000_0013;
      @(negedge clk);
      if (c == 5) begin
        vec++; if (idx !== 2) begin miscmp++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        vec++; if (in_ready0 !== 1'b0) begin miscmp++; $display("FAIL bp_in_ready: got %b want 0", in_ready0); end
      end
      if (out_valid0 && out_ready0) begin
        vec++;
        if (ocnt >= 3 || instr0 !== want[ocnt]) begin
          miscmp++; $display("FAIL bp_order[%0d]: got %h want %h", ocnt, instr0, ocnt < 3 ? want[ocnt] : 32'hx);
        end
        ocnt++; exp_enc0++;
      end
      if (in_valid0 && in_ready0) idx++;
      if (ocnt >= 3 && idx >= 3) break;
    end
    @(posedge clk); #1; in_valid0 = 1'b0;
    vec++; if (ocnt !== 3) begin miscmp++; $display("FAIL bp_outputs: got %0d want 3", ocnt); end
    vec++; if (enc0 !== 16'(exp_enc0)) begin miscmp++; $display("FAIL bp_enc_count: got %0d want %0d", enc0, exp_enc0); end
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [1:0]  err;
    int          acc;
  } exp_t;

  task automatic test_random(input int n_cycles);
    exp_t q[$];
    exp_t h, nw;
    logic exp_rdy, exp_ov;
    for (int cyc = 0; cyc < n_cycles + 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc < n_cycles) begin
        in_valid0  = ($urandom_range(0, 3) != 0);
        immsrc0    = 2'($urandom);
        imm0       = rand_imm();
        base0      = $urandom;
        out_ready0 = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
      end
      @(negedge clk);
      exp_rdy = (q.size() < 2) || out_ready0;
      exp_ov  = (q.size() > 0) && (cyc - q[0].acc >= 2);
      vec++; if (in_ready0 !== exp_rdy) begin miscmp++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready0, exp_rdy); end
      vec++; if (out_valid0 !== exp_ov) begin miscmp++; $display("FAIL rnd_out_valid@%0d: got %b want %b", cyc, out_valid0, exp_ov); end
      if (exp_ov && out_ready0) begin
        h = q.pop_front();
        exp_enc0++;
        vec++; if (instr0 !== h.instr) begin miscmp++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, instr0, h.instr); end
        vec++; if (err0 !== h.err) begin miscmp++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err0, h.err); end
        if (h.err == 2'b00) begin
          vec++; if (extend(h.src, instr0) !== h.imm) begin miscmp++; $display("FAIL rnd_roundtrip@%0d: got %h want %h", cyc, extend(h.src, instr0), h.imm); end
        end
      end
      if (in_valid0 && exp_rdy) begin
        nw.src = immsrc0; nw.imm = imm0; nw.acc = cyc;
        nw.instr = model_enc(immsrc0, imm0, base0);
        nw.err = model_err(immsrc0, imm0);
        if (nw.err != 2'b00) exp_errc0++;
        q.push_back(nw);
      end
    end
    vec++; if (q.size() !== 0) begin miscmp++; $display("FAIL rnd_drain: got %0d left want 0", q.size()); end
    vec++; if (enc0 !== 16'(exp_enc0)) begin miscmp++; $display("FAIL rnd_enc_count: got %0d want %0d", enc0, exp_enc0); end
    vec++; if (errc0 !== 16'(exp_errc0)) begin miscmp++; $display("FAIL rnd_err_count: got %0d want %0d", errc0, exp_errc0); end
    vec++; if (sticky0 !== (exp_errc0 > 0)) begin miscmp++; $display("FAIL rnd_sticky: got %b want %b", sticky0, exp_errc0 > 0); end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    out_ready1 = 1'b1; in_valid1 = 1'b1;
    immsrc1 = 2'b00; imm1 = 32'h0000_0005; base1 = 32'h0000_0013;
    repeat (20) @(posedge clk);
    #1; in_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (enc1 !== 4'hF) begin miscmp++; $display("FAIL sat_enc_count: got %0d want 15", enc1); end
    in_valid1 = 1'b1; immsrc1 = 2'b11; imm1 = 32'h0000_0001;
    repeat (20) @(posedge clk);
    #1; in_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (errc1 !== 4'hF) begin miscmp++; $display("FAIL sat_err_count: got %0d want 15", errc1); end
    vec++; if (enc1 !== 4'hF) begin miscmp++; $display("FAIL sat_enc_after_drop: got %0d want 15", enc1); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    out_ready0 = 1'b0; in_valid0 = 1'b1; immsrc0 = 2'b11; imm0 = 32'h0000_0003; base0 = 32'h0000_006F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    vec++; if (out_valid0 !== 1'b0) begin miscmp++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid0); end
    vec++; if (enc0 !== 16'd0 || errc0 !== 16'd0) begin miscmp++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", enc0, errc0); end
    vec++; if (sticky0 !== 1'b0) begin miscmp++; $display("FAIL rstmid_sticky: got %b want 0", sticky0); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miscmp++; $display("FAIL rstmid_stale: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed("i_roundtrip", 2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
    test_directed("b_pos_edge",  2'b10, 32'h0000_0800, 32'h0000_0063, 32'h0000_00E3, 2'b00);
    test_directed("b_neg_edge",  2'b10, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 2'b00);
    test_directed("j_misalign",  2'b11, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 2'b10);
    test_directed("s_range",     2'b01, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 2'b01);
    test_drop();
    test_backpressure();
    test_random(600);
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
